// File: rtl/ro_puf_race_engine_pkg.sv
// ro_puf_pkg: shared FSM/result encodings, default parameters and the race-result decoder
//   state_t       engine FSM states
//   result_t      outcome of one RO-pair race
//   *_D           default parameter values for the engine
//   race_result   maps the two finish flags onto a race outcome
package ro_puf_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, RACE, RECORD, DONE} state_t;
    typedef enum logic [1:0] {WIN_A, WIN_B, TIE, TIMEOUT} result_t;
    localparam int N_RO_D = 16;
    localparam int SEL_W_D = 4;
    localparam int RESP_BITS_D = 8;
    localparam int CNT_W_D = 16;
    localparam int WIN_W_D = 24;
    localparam logic [CNT_W_D-1:0] THRESH_D = 16'hFFFF;
    function automatic result_t race_result(input logic fin_a, input logic fin_b);
        return (fin_a && fin_b) ? TIE : fin_a ? WIN_A : fin_b ? WIN_B : TIMEOUT;
    endfunction
endpackage

// File: rtl/ro_puf_race_engine_if.sv
// ro_puf_race_engine_if: start/busy/valid handshake and response bus of the PUF engine
//   start, challenge            requester -> engine
//   busy, resp_valid            engine status
//   response, tie_mask, timeout_mask  per-bit race results
interface ro_puf_race_engine_if
    import ro_puf_pkg::*;
#(
    parameter int SEL_W = SEL_W_D,
    parameter int RESP_BITS = RESP_BITS_D
);
    logic start;
    logic [RESP_BITS*2*SEL_W-1:0] challenge;
    logic busy;
    logic resp_valid;
    logic [RESP_BITS-1:0] response;
    logic [RESP_BITS-1:0] tie_mask;
    logic [RESP_BITS-1:0] timeout_mask;
    modport master (output start, challenge, input busy, resp_valid, response, tie_mask, timeout_mask);
    modport slave (input start, challenge, output busy, resp_valid, response, tie_mask, timeout_mask);
endinterface

// File: rtl/ro_puf_race_engine_counter.sv
// ro_edge_counter: synchronizes one RO output, detects rising edges and counts them up to THRESH
//   clk, reset_n  clock, async active-low reset
//   clr           sync clear of synchronizer, edge register and counter
//   en            count enable
//   ro            raw RO output, asynchronous to clk
//   fin           counter has reached THRESH
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W = CNT_W_D,
    parameter logic [CNT_W-1:0] THRESH = THRESH_D
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    input  logic ro,
    output logic fin
);
    // sync[1:0] is the 2-FF synchronizer, sync[2] the previous sample for edge detect
    logic [2:0] sync;
    logic [CNT_W-1:0] cnt;
    assign fin = cnt == THRESH;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            cnt <= '0;
        end else if (clr) begin
            sync <= '0;
            cnt <= '0;
        end else begin
            sync <= {sync[1:0], ro};
            if (en && sync[1] && !sync[2] && !fin) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ro_puf_race_engine.sv
// ro_puf_race_engine: races RO pairs selected by a challenge and shifts out one response bit per pair
//   clk, reset_n  clock, async active-low reset
//   ro_out        raw RO bank outputs
//   bus           handshake/response interface (slave side)
module ro_puf_race_engine
    import ro_puf_pkg::*;
#(
    parameter int N_RO = N_RO_D,
    parameter int SEL_W = SEL_W_D,
    parameter int RESP_BITS = RESP_BITS_D,
    parameter int CNT_W = CNT_W_D,
    parameter logic [CNT_W-1:0] THRESH = THRESH_D,
    parameter int WIN_W = WIN_W_D
) (
    input logic clk,
    input logic reset_n,
    input logic [N_RO-1:0] ro_out,
    ro_puf_race_engine_if.slave bus
);
    localparam int PAIR_W = 2 * SEL_W;
    localparam int IDX_W = RESP_BITS > 1 ? $clog2(RESP_BITS) : 1;
    // Leaving RACE when the timer shows 2**WIN_W-2 gives a window of 2**WIN_W-1 RACE cycles
    localparam logic [WIN_W-1:0] WIN_LAST = {{(WIN_W-1){1'b1}}, 1'b0};
    state_t state, state_nx;
    result_t res;
    logic [RESP_BITS*PAIR_W-1:0] chal;
    logic [IDX_W-1:0] idx;
    logic [WIN_W-1:0] timer;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic [RESP_BITS-1:0] resp, tie, tmo;
    logic ro_a, ro_b, fin_a, fin_b, clr, en, accept;
    assign sel_a = chal[idx*PAIR_W +: SEL_W];
    assign sel_b = chal[idx*PAIR_W+SEL_W +: SEL_W];
    // Indices past the RO bank select a constant 0, so that side never finishes
    assign ro_a = 32'(sel_a) < N_RO ? ro_out[sel_a] : 1'b0;
    assign ro_b = 32'(sel_b) < N_RO ? ro_out[sel_b] : 1'b0;
    assign clr = state == CLEAR;
    // Counting freezes once either side finishes so RECORD sees the finishing cycle only
    assign en = state == RACE && !fin_a && !fin_b;
    assign accept = state == IDLE && bus.start;
    assign res = race_result(fin_a, fin_b);
    assign bus.busy = state != IDLE;
    assign bus.resp_valid = state == DONE;
    assign bus.response = resp;
    assign bus.tie_mask = tie;
    assign bus.timeout_mask = tmo;
    ro_edge_counter #(.CNT_W(CNT_W), .THRESH(THRESH)) u_cnt_a (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .ro(ro_a), .fin(fin_a));
    ro_edge_counter #(.CNT_W(CNT_W), .THRESH(THRESH)) u_cnt_b (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .ro(ro_b), .fin(fin_b));
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = bus.start ? CLEAR : IDLE;
            CLEAR: state_nx = RACE;
            RACE: state_nx = (fin_a || fin_b || timer == WIN_LAST) ? RECORD : RACE;
            RECORD: state_nx = idx == IDX_W'(RESP_BITS - 1) ? DONE : CLEAR;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            chal <= '0;
            idx <= '0;
            timer <= '0;
            resp <= '0;
            tie <= '0;
            tmo <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                chal <= bus.challenge;
                idx <= '0;
                resp <= '0;
                tie <= '0;
                tmo <= '0;
            end
            if (clr) timer <= '0;
            else if (state == RACE) timer <= timer + 1'b1;
            if (state == RECORD) begin
                resp[idx] <= res == WIN_A;
                tie[idx] <= res == TIE;
                tmo[idx] <= res == TIMEOUT;
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ro_puf_race_engine.sv
// tb_ro_puf_race_engine: scoreboard bench driving free-running ROs against a rate-based reference model
`timescale 1ns/1ps
module tb_ro_puf_race_engine;
    import ro_puf_pkg::*;
    localparam int N_RO = 12;
    localparam int SEL_W = 4;
    localparam int RB = 8;
    localparam int CNT_W = 8;
    localparam int WIN_W = 8;
    localparam logic [CNT_W-1:0] THRESH = 8'd16;
    localparam int CW = RB * 2 * SEL_W;
    // RO period in clk cycles; 0 means the RO is stuck low
    localparam int PER [N_RO] = '{4, 6, 0, 8, 0, 10, 0, 12, 0, 0, 0, 0};
    localparam int BIT_TMO = (2**WIN_W - 1) + 2;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    wire [N_RO-1:0] ro_out;
    int checks = 0;
    int errors = 0;
    int lat;
    logic [3*RB-1:0] exp_q [$];
    logic [3*RB-1:0] mon_exp;
    ro_puf_race_engine_if #(.SEL_W(SEL_W), .RESP_BITS(RB)) bus ();
    ro_puf_race_engine #(
        .N_RO(N_RO), .SEL_W(SEL_W), .RESP_BITS(RB), .CNT_W(CNT_W), .THRESH(THRESH), .WIN_W(WIN_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ro_out(ro_out), .bus(bus)
    );
    always #5 clk = ~clk;
    for (genvar g = 0; g < N_RO; g++) begin : g_ro
        logic r = 1'b0;
        initial if (PER[g] != 0) begin
            #(0.7 + 1.3 * g);
            forever #(PER[g] * 5.0) r = ~r;
        end
        assign ro_out[g] = r;
    end
    // Faster RO reaches THRESH edges first; a stuck side never finishes; same RO on both sides ties
    function automatic logic [3*RB-1:0] model(input logic [CW-1:0] ch);
        logic [RB-1:0] rsp, tie, tmo;
        int a, b, pa, pb;
        rsp = '0;
        tie = '0;
        tmo = '0;
        for (int i = 0; i < RB; i++) begin
            a = int'(ch[i*2*SEL_W +: SEL_W]);
            b = int'(ch[i*2*SEL_W+SEL_W +: SEL_W]);
            pa = a < N_RO ? PER[a] : 0;
            pb = b < N_RO ? PER[b] : 0;
            if (pa == 0 && pb == 0) tmo[i] = 1'b1;
            else if (a == b) tie[i] = 1'b1;
            else if (pb == 0 || (pa != 0 && pa < pb)) rsp[i] = 1'b1;
        end
        return {rsp, tie, tmo};
    endfunction
    function automatic logic [CW-1:0] rep(input logic [SEL_W-1:0] c1, input logic [SEL_W-1:0] c0);
        logic [CW-1:0] v;
        v = '0;
        for (int i = 0; i < RB; i++) v[i*2*SEL_W +: 2*SEL_W] = {c1, c0};
        return v;
    endfunction
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask
    always @(negedge clk) if (reset_n && bus.resp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected got=%h expected=none", {bus.response, bus.tie_mask, bus.timeout_mask});
        end else begin
            mon_exp = exp_q.pop_front();
            if ({bus.response, bus.tie_mask, bus.timeout_mask} !== mon_exp) begin
                errors++;
                $display("FAIL resp got=%h expected=%h", {bus.response, bus.tie_mask, bus.timeout_mask}, mon_exp);
            end
        end
    end
    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_wait", 32'(bus.busy), 0);
    endtask
    task automatic do_run(input logic [CW-1:0] ch, input bit dup, output int cyc);
        wait_idle();
        @(negedge clk);
        bus.challenge = ch;
        bus.start = 1'b1;
        exp_q.push_back(model(ch));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.challenge = CW'({$urandom, $urandom});
        check("busy_rise", 32'(bus.busy), 1);
        check("clear_on_accept", 32'({bus.response, bus.tie_mask, bus.timeout_mask}), 0);
        cyc = 0;
        while (!bus.resp_valid && cyc < RB * BIT_TMO + 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (dup && cyc == 20) begin
                bus.start = 1'b1;
                bus.challenge = ~ch;
            end
            if (cyc == 21) bus.start = 1'b0;
        end
        check("run_done", 32'(bus.resp_valid), 1);
        @(posedge clk);
        #1;
        check("valid_pulse_busy_fall", 32'({bus.resp_valid, bus.busy}), 0);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.challenge = '0;
        #2 reset_n = 1'b0;
        #20;
        check("reset_out", 32'({bus.busy, bus.resp_valid, bus.response, bus.tie_mask, bus.timeout_mask}), 0);
        @(negedge clk) reset_n = 1'b1;
        do_run(rep(5, 3), 1'b0, lat);
        do_run(rep(3, 5), 1'b0, lat);
        do_run(rep(7, 7), 1'b0, lat);
        do_run(rep(13, 3), 1'b0, lat);
        do_run(rep(14, 13), 1'b0, lat);
        check("timeout_latency", 32'(lat), 32'(RB * BIT_TMO));
        for (int k = 0; k < 8; k++) do_run(CW'({$urandom, $urandom}), k[0], lat);
        wait_idle();
        @(negedge clk);
        bus.challenge = rep(11, 9);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3 * BIT_TMO + 50) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("reset_mid_race", 32'({bus.busy, bus.resp_valid, bus.response, bus.tie_mask, bus.timeout_mask}), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("idle_after_reset", 32'(bus.busy), 0);
        do_run(rep(1, 0), 1'b0, lat);
        do_run(CW'({$urandom, $urandom}), 1'b1, lat);
        repeat (3) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
